// File: rtl/lpcm_arbiter_if.sv
// Request/sample bus shared by the LPCM arbiter and its sequence sources.
// The arbiter takes the slave view; the sources (or a bench) take the master view.
interface lpcm_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int SAMPLE_W = 24,
  parameter int LAT_W    = 8
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*SAMPLE_W-1:0] req_sample;
  logic [N_REQ*LAT_W-1:0]    req_latency;
  logic [N_REQ-1:0]          req_ack;
  logic                      pause;
  logic                      lpcm_en;
  logic [SAMPLE_W-1:0]       lpcm_data;
  logic [SRC_W-1:0]          lpcm_src;
  logic                      busy;

  modport master (
    output req_valid, req_sample, req_latency, pause,
    input  req_ack, lpcm_en, lpcm_data, lpcm_src, busy
  );

  modport slave (
    input  req_valid, req_sample, req_latency, pause,
    output req_ack, lpcm_en, lpcm_data, lpcm_src, busy
  );
endinterface

// File: rtl/lpcm_arbiter.sv
// Round-robin arbiter sharing one LPCM sample output between N_REQ requesters,
// with a per-grant latency gap. Optional grant statistics under LPCM_ARB_STATS_EN.
module lpcm_arbiter #(
  parameter int N_REQ    = 4,
  parameter int SAMPLE_W = 24,
  parameter int LAT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
`ifdef LPCM_ARB_STATS_EN
  input  logic                stats_clr,
  output logic [N_REQ*16-1:0] grant_cnt,
`endif
  lpcm_arbiter_if.slave       bus
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [SAMPLE_W-1:0] sample_arr [N_REQ];
  logic [LAT_W-1:0]    lat_arr    [N_REQ];

  logic [LAT_W-1:0]    cnt_reg,  cnt_next;
  logic                en_reg,   en_next;
  logic [SAMPLE_W-1:0] data_reg, data_next;
  logic [SRC_W-1:0]    src_reg,  src_next;
  logic [SRC_W-1:0]    last_reg, last_next;

  logic                win_found;
  logic [SRC_W-1:0]    win_idx;
  logic [SRC_W-1:0]    cand;
  logic                grant;
  logic [N_REQ-1:0]    ack_vec;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign sample_arr[gi] = bus.req_sample[gi*SAMPLE_W +: SAMPLE_W];
      assign lat_arr[gi]    = bus.req_latency[gi*LAT_W +: LAT_W];
    end
  endgenerate

  // Search starts one past the last winner and wraps, so the most recent
  // winner always has the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = SRC_W'((int'(last_reg) + k) % N_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant   = !reset && (cnt_reg == '0) && !bus.pause && win_found;
  assign ack_vec = grant ? (N_REQ'(1) << win_idx) : '0;

  always_comb begin
    en_next   = 1'b0;
    data_next = data_reg;
    src_next  = src_reg;
    last_next = last_reg;
    cnt_next  = cnt_reg;
    if (grant) begin
      en_next   = 1'b1;
      data_next = sample_arr[win_idx];
      src_next  = win_idx;
      last_next = win_idx;
      cnt_next  = lat_arr[win_idx];
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      en_reg   <= 1'b0;
      data_reg <= '0;
      src_reg  <= '0;
      last_reg <= SRC_W'(N_REQ - 1);
    end else begin
      cnt_reg  <= cnt_next;
      en_reg   <= en_next;
      data_reg <= data_next;
      src_reg  <= src_next;
      last_reg <= last_next;
    end
  end

  assign bus.req_ack   = ack_vec;
  assign bus.lpcm_en   = en_reg;
  assign bus.lpcm_data = data_reg;
  assign bus.lpcm_src  = src_reg;
  assign bus.busy      = (cnt_reg != '0);

`ifdef LPCM_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
      logic [15:0] gcnt_reg;
      // Clear takes precedence over a same-cycle grant.
      always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
          gcnt_reg <= '0;
        end else if (ack_vec[gi] && (gcnt_reg != 16'hFFFF)) begin
          gcnt_reg <= gcnt_reg + 16'd1;
        end
      end
      assign grant_cnt[gi*16 +: 16] = gcnt_reg;
    end
  endgenerate
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_lpcm_arbiter.sv
// Self-checking bench for lpcm_arbiter: timestamp-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_lpcm_arbiter;
  localparam int N    = 4;
  localparam int SW   = 24;
  localparam int LW   = 8;
  localparam int SRCW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lpcm_arbiter_if #(.N_REQ(N), .SAMPLE_W(SW), .LAT_W(LW)) bus_if ();

`ifdef LPCM_ARB_STATS_EN
  logic            stats_clr;
  logic [N*16-1:0] grant_cnt;
`endif

  lpcm_arbiter #(.N_REQ(N), .SAMPLE_W(SW), .LAT_W(LW)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef LPCM_ARB_STATS_EN
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt),
`endif
    .bus       (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit verbose  = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a grant is allowed from cycle next_allowed onward; a grant
  // at cycle t with latency L pushes that to t+1+L. busy is "before next_allowed".
  int              cyc          = 0;
  int              next_allowed = 0;
  int              m_last       = N - 1;
  logic            m_en         = 1'b0;
  logic [SW-1:0]   m_data       = '0;
  int              m_src        = 0;
  logic [N-1:0]    model_ack    = '0;
  logic [N-1:0]    cm_ack;
  int              cm_win;
  int              cm_idx;

  always @(negedge clk) begin
    cm_ack = '0;
    cm_win = -1;
    if (reset !== 1'b1 && cyc >= next_allowed && bus_if.pause !== 1'b1) begin
      for (int k = 1; k <= N; k++) begin
        cm_idx = (m_last + k) % N;
        if (cm_win < 0 && bus_if.req_valid[cm_idx] === 1'b1) cm_win = cm_idx;
      end
    end
    if (cm_win >= 0) cm_ack[cm_win] = 1'b1;

    chk("ack",  64'(bus_if.req_ack),   64'(cm_ack));
    chk("en",   64'(bus_if.lpcm_en),   64'(m_en));
    chk("data", 64'(bus_if.lpcm_data), 64'(m_data));
    chk("src",  64'(bus_if.lpcm_src),  64'(m_src));
    chk("busy", 64'(bus_if.busy),      64'(cyc < next_allowed));
    if (verbose && m_en)
      $display("t=%0t sample src=%0d data=%06h", $time, m_src, m_data);

    if (reset === 1'b1) begin
      m_en = 1'b0; m_data = '0; m_src = 0; m_last = N - 1;
      next_allowed = cyc + 1;
    end else if (cm_win >= 0) begin
      m_en   = 1'b1;
      m_data = bus_if.req_sample[cm_win*SW +: SW];
      m_src  = cm_win;
      m_last = cm_win;
      next_allowed = cyc + 1 + int'(bus_if.req_latency[cm_win*LW +: LW]);
    end else begin
      m_en = 1'b0;
    end
    model_ack = cm_ack;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [SW-1:0] s, input logic [LW-1:0] l);
    bus_if.req_valid[i]           = v;
    bus_if.req_sample[i*SW +: SW] = s;
    bus_if.req_latency[i*LW +: LW] = l;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.req_valid = '0;
    bus_if.pause     = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  int last_pulse, busy_count, pulses;
  int order [6] = '{0, 1, 2, 3, 0, 1};
  logic [N-1:0]    rv;
  logic [SW-1:0]   rs;
  logic [LW-1:0]   rl;
  int              r;

  initial begin
    reset = 1'b1;
    bus_if.req_valid   = '0;
    bus_if.req_sample  = '0;
    bus_if.req_latency = '0;
    bus_if.pause       = 1'b0;
`ifdef LPCM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    tick();
    reset = 1'b0;

    // Requester 0 alone, latency 0, samples 1..4 back to back.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      set_req(0, 1'b1, SW'(k), 8'd0);
      @(negedge clk);
      chk("t1_ack", 64'(bus_if.req_ack), 64'h1);
      if (k > 1) begin
        chk("t1_en",   64'(bus_if.lpcm_en),   64'h1);
        chk("t1_data", 64'(bus_if.lpcm_data), 64'(k - 1));
        chk("t1_src",  64'(bus_if.lpcm_src),  64'h0);
      end
      tick();
    end
    bus_if.req_valid = '0;
    @(negedge clk);
    chk("t1_en_last",   64'(bus_if.lpcm_en),   64'h1);
    chk("t1_data_last", 64'(bus_if.lpcm_data), 64'h4);
    tick();
    @(negedge clk);
    chk("t1_en_off", 64'(bus_if.lpcm_en), 64'h0);
    tick();

    // Requester 2 alone, latency 3: pulses 4 cycles apart, 3 busy cycles each.
    do_reset();
    set_req(2, 1'b1, 24'hABCDEF, 8'd3);
    last_pulse = -1; busy_count = 0; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_if.lpcm_en === 1'b1) begin
        pulses++;
        if (last_pulse >= 0) begin
          chk("t2_gap",  64'(c - last_pulse), 64'd4);
          chk("t2_busy", 64'(busy_count),     64'd3);
        end
        busy_count = 0;
        last_pulse = c;
      end
      if (bus_if.busy === 1'b1) busy_count++;
      tick();
    end
    chk("t2_pulses", 64'(pulses), 64'd5);

    // All four valid, latency 0: strict rotation starting at 0.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, SW'(i + 16), 8'd0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("t3_order", 64'(bus_if.req_ack), 64'(1 << order[j]));
      tick();
    end

    // Requesters 1 and 3 under pause, then released.
    do_reset();
    set_req(1, 1'b1, 24'h000111, 8'd0);
    set_req(3, 1'b1, 24'h000333, 8'd0);
    bus_if.pause = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("t4_pause_ack", 64'(bus_if.req_ack), 64'h0);
      tick();
    end
    bus_if.pause = 1'b0;
    @(negedge clk);
    chk("t4_first", 64'(bus_if.req_ack), 64'h2);
    tick();
    @(negedge clk);
    chk("t4_second", 64'(bus_if.req_ack), 64'h8);
    tick();

    // Long gap interrupted by reset; grant resumes right after release.
    do_reset();
    set_req(0, 1'b1, 24'h0000C8, 8'd200);
    @(negedge clk);
    chk("t5_ack", 64'(bus_if.req_ack), 64'h1);
    tick();
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("t5_gap_busy", 64'(bus_if.busy),    64'h1);
      chk("t5_gap_ack",  64'(bus_if.req_ack), 64'h0);
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_ack", 64'(bus_if.req_ack), 64'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_post_busy", 64'(bus_if.busy),    64'h0);
    chk("t5_post_en",   64'(bus_if.lpcm_en), 64'h0);
    chk("t5_post_ack",  64'(bus_if.req_ack), 64'h1);
    tick();

`ifdef LPCM_ARB_STATS_EN
    // Grant statistics: 10 to requester 1, 5 to requester 2, then clear.
    do_reset();
    for (int j = 0; j < 10; j++) begin
      set_req(1, 1'b1, SW'(j), 8'd0);
      @(negedge clk);
      tick();
    end
    bus_if.req_valid = '0;
    for (int j = 0; j < 5; j++) begin
      set_req(2, 1'b1, SW'(j), 8'd0);
      @(negedge clk);
      tick();
    end
    bus_if.req_valid = '0;
    tick();
    @(negedge clk);
    chk("stats_cnt1", 64'(grant_cnt[16 +: 16]), 64'd10);
    chk("stats_cnt2", 64'(grant_cnt[32 +: 16]), 64'd5);
    chk("stats_cnt0", 64'(grant_cnt[0 +: 16]),  64'd0);
    tick();
    set_req(1, 1'b1, 24'h1, 8'd0);
    stats_clr = 1'b1;
    @(negedge clk);
    chk("stats_clr_ack", 64'(bus_if.req_ack), 64'h2);
    tick();
    stats_clr = 1'b0;
    bus_if.req_valid = '0;
    @(negedge clk);
    chk("stats_clr_cnt1", 64'(grant_cnt[16 +: 16]), 64'd0);
    tick();
`endif

    // Random traffic against the model.
    verbose = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 299) == 0);
      bus_if.pause = ($urandom_range(0, 7) == 0);
      rv = bus_if.req_valid;
      for (int i = 0; i < N; i++) begin
        if (model_ack[i] || !rv[i]) begin
          rs = SW'($urandom);
          r  = int'($urandom_range(0, 15));
          if (r < 8)        rl = 8'd0;
          else if (r < 14)  rl = LW'($urandom_range(1, 6));
          else if (r == 14) rl = LW'($urandom_range(7, 40));
          else              rl = 8'd255;
          set_req(i, ($urandom_range(0, 2) != 0), rs, rl);
        end else if ($urandom_range(0, 15) == 0) begin
          bus_if.req_valid[i] = 1'b0;
        end
      end
      tick();
    end
    reset = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/lpcm_arbiter.md
Name: lpcm_arbiter

Overview:
- Shares one LPCM sample output (en/data pair) between N_REQ independent sample requesters.
- Uses round-robin arbitration and per-grant latency gaps: after a sample issues, the owning request's latency field blanks the output for that many cycles before the next grant.
- Sits between multiple sequence sources and the single LPCM interface drive point on the bench/datapath side.

Parameters:
N_REQ, 4, number of requesters (2..16)
SAMPLE_W, 24, sample width in bits
LAT_W, 8, latency field width in bits (gap cycles after a sample)

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
req_valid  input  N_REQ  per-requester request; held with payload stable until acked
req_sample  input  N_REQ*SAMPLE_W  flattened samples, requester i at [i*SAMPLE_W +: SAMPLE_W]
req_latency  input  N_REQ*LAT_W  flattened gap lengths, requester i at [i*LAT_W +: LAT_W]
req_ack  output  N_REQ  one-hot combinational grant/ack; request consumed this cycle
pause  input  1  blocks new grants while high; gap counter keeps running
lpcm_en  output  1  registered sample strobe to LPCM interface
lpcm_data  output  SAMPLE_W  registered sample
lpcm_src  output  $clog2(N_REQ)  index of requester owning current lpcm_en pulse
busy  output  1  high while gap counter nonzero

Behaviour:
- Reset (sync, highest priority):
  - gap counter = 0, lpcm_en = 0, lpcm_data = 0, lpcm_src = 0.
  - RR pointer last = N_REQ-1, so requester 0 has first priority.
  - req_ack is combinationally 0 while reset is high.
- Grant condition (combinational): counter == 0 && !pause && |req_valid.
  - Winner is the first valid index searching last+1, last+2, ... modulo N_REQ.
  - req_ack[winner] = 1; all other ack bits 0. Never more than one ack bit high.
- On a grant cycle (registered at next edge):
  - lpcm_en <= 1; lpcm_data <= winner sample; lpcm_src <= winner; last <= winner; counter <= winner latency.
- Non-grant cycle:
  - lpcm_en <= 0; lpcm_data and lpcm_src hold their values.
  - If counter > 0, counter decrements by 1 (no wrap below 0).
- Latency and spacing:
  - ack→lpcm_en latency is 1 cycle.
  - Latency L gives a minimum of L+1 cycles between successive lpcm_en pulses.
  - L = 0 allows back-to-back pulses every cycle.
- Gap: no ack is issued while counter > 0, regardless of req_valid.
- pause:
  - Blocks grants only; an in-flight lpcm_en (already registered) still appears.
  - Counter still decrements during pause.
- Dropped valid: req_valid deasserting without ack is legal. Nothing is recorded and the pointer is unchanged.
- Single requester: that requester is re-granted repeatedly; the RR pointer has no effect.
- busy = (counter != 0).
- Reset mid-gap: counter cleared immediately, and the next cycle after reset release may grant.
- Latency width: arithmetic is LAT_W-bit unsigned; max gap is 2^LAT_W-1.

Optional Feature:
LPCM_ARB_STATS_EN
- Defined: adds output grant_cnt, N_REQ*16 bits, flattened.
  - Per-requester 16-bit counter increments on each req_ack[i].
  - Saturates at 0xFFFF; cleared by reset.
  - Adds input stats_clr (1 bit, synchronous, clears all counters). Clear wins over a same-cycle increment.
- Undefined: neither port exists and no counter logic is built; all other behaviour is identical.

Test Plan:
- Requester 0 only, valid held, latency 0, samples 0x000001..0x000004: acks on 4 consecutive cycles; lpcm_en high 4 consecutive cycles one cycle later; data 1,2,3,4; lpcm_src = 0.
- Requester 2 only, latency 3: lpcm_en pulses exactly 4 cycles apart; busy high for the 3 cycles after each pulse.
- All 4 valid continuously, latency 0, after reset: grant order 0,1,2,3,0,1; exactly one ack bit per cycle.
- Requesters 1 and 3 valid, pause high 5 cycles then low: no acks during pause; first ack to 1, then 3.
- Latency 200 grant, reset asserted 10 cycles later for 1 cycle: busy = 0 and lpcm_en = 0 after reset; requester 0 acked on the first cycle after release.
- With LPCM_ARB_STATS_EN: 10 grants to 1 and 5 to 2, then grant_cnt[1] = 10, grant_cnt[2] = 5. stats_clr coincident with a grant gives 0.
